// File: rtl/soc_system_coprocessor_cmd_queue.sv
// Avalon-MM fed instruction FIFO that issues words one at a time to the matrix
// coprocessor over valid/ready, then captures the result on the done pulse.
module soc_system_coprocessor_cmd_queue #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int RESULT_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  output logic [DATA_W-1:0]   cmd_data,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  input  logic                done,
  input  logic [RESULT_W-1:0] result,
  output logic                irq
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [DATA_W-1:0]   last_wr;
  logic [RESULT_W-1:0] result_q;
  logic                overflow, done_flag, irq_en;

  logic wr_en, push_req, cmd_wr, flush, ovf_clr, done_clr, irq_wr;
  logic empty, full, pop, push_ok, done_ok;
  logic [7:0] count8;

  assign wr_en    = chipselect & ~write_n;
  assign push_req = wr_en & (address == 2'd0);
  assign cmd_wr   = wr_en & (address == 2'd1);
  assign irq_wr   = wr_en & (address == 2'd3);
  assign flush    = cmd_wr & writedata[0];
  assign ovf_clr  = cmd_wr & writedata[1];
  assign done_clr = cmd_wr & writedata[2];

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign pop     = (state == S_ISSUE) & cmd_ready;
  // A pop in the same cycle frees the slot, so a push into a full queue is legal then.
  assign push_ok = push_req & (~full | pop);
  assign done_ok = (state == S_WAIT) & done;
  assign count8  = 8'(count);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= writedata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as its clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_wr   <= '0;
      result_q  <= '0;
      overflow  <= 1'b0;
      done_flag <= 1'b0;
      irq_en    <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (push_req) last_wr <= writedata;
      if (push_req & full & ~pop) overflow <= 1'b1;
      else if (ovf_clr)           overflow <= 1'b0;
      if (done_ok) begin
        result_q  <= result;
        done_flag <= 1'b1;
      end else if (done_clr) begin
        done_flag <= 1'b0;
      end
      if (irq_wr) irq_en <= writedata[0];
      irq <= irq_en & (done_flag | overflow);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // A flush in IDLE also blocks the move to ISSUE so an emptied queue is never offered.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!empty && !flush) state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (cmd_ready)  state_nxt = S_WAIT;
        else if (flush) state_nxt = S_IDLE;
      end
      S_WAIT:  if (done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign cmd_valid = (state == S_ISSUE);
  assign cmd_data  = (state == S_ISSUE) ? mem[rd_ptr] : '0;

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata = last_wr;
      2'd1: begin
        readdata[0]    = empty;
        readdata[1]    = full;
        readdata[2]    = (state != S_IDLE);
        readdata[3]    = overflow;
        readdata[4]    = done_flag;
        readdata[15:8] = count8;
      end
      2'd2:    readdata[RESULT_W-1:0] = result_q;
      default: readdata[0] = irq_en;
    endcase
  end

endmodule

// File: tb/tb_soc_system_coprocessor_cmd_queue.sv
// Bench for the coprocessor command queue: directed scenarios then random traffic,
// every cycle compared against a queue-based reference model.
module tb_soc_system_coprocessor_cmd_queue;

  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [1:0]    address = 2'd1;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [DW-1:0] writedata = '0;
  logic [DW-1:0] readdata, cmd_data;
  logic          cmd_valid, irq;
  logic          cmd_ready = 1'b0;
  logic          done = 1'b0;
  logic [RW-1:0] result = '0;

  soc_system_coprocessor_cmd_queue #(.DATA_W(DW), .DEPTH(DEPTH), .RESULT_W(RW)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .done(done), .result(result), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: pending words in a queue, plus offered/outstanding phase bits.
  logic [DW-1:0] q[$];
  bit            m_off, m_wait, m_ovf, m_done, m_irqen, m_irq;
  logic [DW-1:0] m_last;
  logic [RW-1:0] m_res;
  int            ncmp = 0;
  int            nerr = 0;

  task automatic model_reset();
    q.delete();
    m_off = 0; m_wait = 0; m_ovf = 0; m_done = 0; m_irqen = 0; m_irq = 0;
    m_last = '0; m_res = '0;
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [1:0] a);
    logic [DW-1:0] s;
    s = '0;
    case (a)
      2'd0: s = m_last;
      2'd1: begin
        s[0] = (q.size() == 0);
        s[1] = (q.size() == DEPTH);
        s[2] = m_off | m_wait;
        s[3] = m_ovf;
        s[4] = m_done;
        s[15:8] = 8'(q.size());
      end
      2'd2: s[RW-1:0] = m_res;
      default: s[0] = m_irqen;
    endcase
    return s;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check();
    chk("cmd_valid", DW'(cmd_valid), DW'(m_off));
    if (m_off) chk("cmd_data", cmd_data, q[0]);
    chk("irq", DW'(irq), DW'(m_irq));
    chk($sformatf("readdata@%0d", address), readdata, exp_rd(address));
  endtask

  task automatic model_step();
    bit wr, push_req, cmdw, flush, pop, full, irq_nxt;
    int sz;
    wr       = chipselect && !write_n;
    push_req = wr && (address == 2'd0);
    cmdw     = wr && (address == 2'd1);
    flush    = cmdw && writedata[0];
    sz       = q.size();
    full     = (sz == DEPTH);
    pop      = m_off && cmd_ready;
    irq_nxt  = m_irqen & (m_done | m_ovf);
    if (cmdw && writedata[1]) m_ovf = 0;
    if (cmdw && writedata[2]) m_done = 0;
    if (m_off) begin
      if (pop) begin m_off = 0; m_wait = 1; end
      else if (flush) m_off = 0;
    end else if (m_wait) begin
      if (done) begin m_wait = 0; m_done = 1; m_res = result; end
    end else if (sz != 0 && !flush) begin
      m_off = 1;
    end
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push_req && (!full || pop)) q.push_back(writedata);
    end
    if (push_req && full && !pop) m_ovf = 1;
    if (push_req) m_last = writedata;
    if (wr && address == 2'd3) m_irqen = writedata[0];
    m_irq = irq_nxt;
  endtask

  task automatic cyc();
    #1;
    check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic run_done(input int n, input logic [RW-1:0] r);
    for (int i = 0; i < n; i++) begin
      done = m_wait;
      result = r;
      cyc();
    end
    done = 1'b0;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [DW-1:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    cyc();
    chipselect = 1'b0; write_n = 1'b1; address = 2'd1;
  endtask

  task automatic rd(input logic [1:0] a);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    cyc();
    chipselect = 1'b0; address = 2'd1;
  endtask

  task automatic do_reset();
    chipselect = 1'b0; write_n = 1'b1; cmd_ready = 1'b0; done = 1'b0; address = 2'd1;
    reset_n = 1'b0;
    model_reset();
    #1;
    check();
    @(posedge clk);
    #1;
    check();
    reset_n = 1'b1;
  endtask

  task automatic wait_wait();
    for (int i = 0; i < 12 && !m_wait; i++) cyc();
  endtask

  initial begin
    #3;
    do_reset();
    rd(2'd1); rd(2'd2); rd(2'd3); rd(2'd0);

    // single instruction
    cmd_ready = 1'b1;
    wr_reg(2'd0, 32'hA5A5_0001);
    run(2);
    rd(2'd1);
    run_done(3, 16'h1234);
    rd(2'd2); rd(2'd1);

    // fill past full with the consumer stalled, then drain in order
    cmd_ready = 1'b0;
    for (int i = 0; i < 10; i++) wr_reg(2'd0, 32'hC0DE_0000 + i);
    rd(2'd1); rd(2'd0);
    run(2);
    cmd_ready = 1'b1;
    run_done(40, 16'h0055);
    rd(2'd1);

    // flush while offering, then flush while outstanding
    cmd_ready = 1'b0;
    wr_reg(2'd1, 32'h2);
    for (int i = 0; i < 3; i++) wr_reg(2'd0, 32'h0F0F_0000 + i);
    run(2);
    wr_reg(2'd1, 32'h1);
    rd(2'd1);
    run(2);
    wr_reg(2'd0, 32'h1357_0001);
    wr_reg(2'd0, 32'h1357_0002);
    cmd_ready = 1'b1;
    wait_wait();
    cmd_ready = 1'b0;
    wr_reg(2'd1, 32'h1);
    rd(2'd1);
    run(2);
    run_done(3, 16'h0077);
    rd(2'd1);

    // interrupt set, clear, and clear coincident with done
    wr_reg(2'd1, 32'h6);
    wr_reg(2'd3, 32'h1);
    cmd_ready = 1'b1;
    wr_reg(2'd0, 32'h1111_1111);
    run_done(6, 16'hBEEF);
    run(2);
    wr_reg(2'd1, 32'h4);
    run(2);
    wr_reg(2'd0, 32'h2222_2222);
    wait_wait();
    chipselect = 1'b1; write_n = 1'b0; address = 2'd1; writedata = 32'h4;
    done = 1'b1; result = 16'h3333;
    cyc();
    chipselect = 1'b0; write_n = 1'b1; done = 1'b0;
    run(3);
    rd(2'd3); rd(2'd2);

    // push into a full queue in the same cycle as the handshake
    cmd_ready = 1'b0;
    wr_reg(2'd1, 32'h3);
    for (int i = 0; i < DEPTH; i++) wr_reg(2'd0, 32'hF00D_0000 + i);
    for (int i = 0; i < 4 && !m_off; i++) cyc();
    cmd_ready = 1'b1;
    wr_reg(2'd0, 32'hF00D_00FF);
    cmd_ready = 1'b0;
    rd(2'd1);
    cmd_ready = 1'b1;
    run_done(40, 16'h0099);
    rd(2'd1);

    // random traffic with one reset mid-stream
    for (int i = 0; i < 3000; i++) begin
      int r;
      if (i == 1500) do_reset();
      r = int'($urandom_range(0, 7));
      chipselect = 1'b1;
      write_n = 1'b0;
      writedata = $urandom;
      if (r < 3) address = 2'd0;
      else if (r == 3) begin
        address = 2'd1;
        writedata = {29'd0, $urandom_range(0, 3) == 0 ? 1'b1 : 1'b0, 2'($urandom_range(0, 3))};
        if (writedata[2:1] != 2'b00) writedata[0] = ($urandom_range(0, 7) == 0);
      end
      else if (r == 4) address = 2'd3;
      else if (r == 5) address = 2'd2;
      else begin
        address = 2'($urandom_range(0, 3));
        write_n = 1'b1;
        chipselect = 1'($urandom_range(0, 1));
      end
      cmd_ready = ($urandom_range(0, 2) != 0);
      done = ($urandom_range(0, 2) == 0);
      result = 16'($urandom);
      cyc();
    end
    chipselect = 1'b0; write_n = 1'b1; done = 1'b0;
    rd(2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
